// File: rtl/lut_lookup_scheduler_if.sv
// Bundles the lookup request, config-write and response signals of lut_lookup_scheduler.
//   req_valid/req_index/req_ready : per-requester lookup handshake (req_ready is the grant)
//   cfg_we/cfg_addr/cfg_data      : table write port
//   rsp_valid/rsp_id/rsp_data/rsp_ready : registered response handshake
// modport master: the client side, which drives requests, config writes and rsp_ready.
// modport slave:  the scheduler.
interface lut_lookup_scheduler_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_index;
    logic [NREQ-1:0]   req_ready;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [DW-1:0]     cfg_data;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_ready;

    modport master (
        output req_valid, req_index, cfg_we, cfg_addr, cfg_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_index, cfg_we, cfg_addr, cfg_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/lut_lookup_scheduler.sv
// Shares one 4-entry lookup table (2-bit index -> DW-bit value) among NREQ requesters.
// Requests are arbitrated round-robin; the winner's lookup result and ID are returned
// through a one-entry registered response stage with valid/ready backpressure.
// The module owns the table and is its only writer (via the cfg port).
// Ports:
//   clock_reset[0] : clock, rising edge
//   clock_reset[1] : reset, asynchronous, active-high
//   dif            : slave side of lut_lookup_scheduler_if (requests, config, response)
module lut_lookup_scheduler #(
    parameter int unsigned      NREQ       = 4,
    parameter int unsigned      DW         = 4,
    parameter logic [4*DW-1:0]  TABLE_INIT = 16'h4321
) (
    input  logic [1:0]               clock_reset,
    lut_lookup_scheduler_if.slave    dif
);

    typedef enum logic {StEmpty, StFull} state_e;

    logic clk;
    logic rst;
    assign clk = clock_reset[0];
    assign rst = clock_reset[1];

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    rsp_id_q, rsp_id_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [DW-1:0] table_q [4];
    logic [DW-1:0] table_d [4];

    logic          can_issue;
    logic          grant;
    logic [1:0]    win;
    logic [1:0]    cand;
    logic [1:0]    win_index;

    // rsp_ready feeds the grant combinationally so a full stage can drain and refill each cycle.
    assign can_issue = (state_q == StEmpty) | dif.rsp_ready;

    // Round-robin scan starting at ptr_q; 2-bit arithmetic provides the mod-4 wrap.
    always_comb begin
        grant = 1'b0;
        win   = 2'd0;
        cand  = 2'd0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = ptr_q + 2'(i);
            if (can_issue && !grant && dif.req_valid[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_index     = dif.req_index[{win, 1'b0} +: 2];
    assign dif.req_ready = grant ? (NREQ'(1) << win) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        if (grant) begin
            state_d    = StFull;
            ptr_d      = win + 2'd1;
            rsp_id_d   = win;
            // Reads the pre-write table, so a same-cycle write to this entry returns old data.
            rsp_data_d = table_q[win_index];
        end else if (dif.rsp_ready) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            table_d[k] = table_q[k];
        end
        if (dif.cfg_we) begin
            table_d[dif.cfg_addr] = dif.cfg_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            ptr_q      <= 2'd0;
            rsp_id_q   <= 2'd0;
            rsp_data_q <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                table_q[k] <= TABLE_INIT[k*DW +: DW];
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            for (int unsigned k = 0; k < 4; k++) begin
                table_q[k] <= table_d[k];
            end
        end
    end

    assign dif.rsp_valid = (state_q == StFull);
    assign dif.rsp_id    = rsp_id_q;
    assign dif.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_lut_lookup_scheduler.sv
// Directed bench for lut_lookup_scheduler: reset state, single lookup latency, round-robin
// under full load, backpressure, write/lookup collision, wrap, and mid-operation reset.
module tb_lut_lookup_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    lut_lookup_scheduler_if #(.NREQ(4), .DW(4)) dif ();

    lut_lookup_scheduler #(
        .NREQ       (4),
        .DW         (4),
        .TABLE_INIT (16'h4321)
    ) dut (
        .clock_reset ({rst, clk}),
        .dif         (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] d);
        chk({tag, ".valid"}, 32'(dif.rsp_valid), 32'(v));
        chk({tag, ".id"},    32'(dif.rsp_id),    32'(id));
        chk({tag, ".data"},  32'(dif.rsp_data),  32'(d));
    endtask

    initial begin
        dif.req_valid = '0;
        dif.req_index = '0;
        dif.cfg_we    = 1'b0;
        dif.cfg_addr  = '0;
        dif.cfg_data  = '0;
        dif.rsp_ready = 1'b0;

        // Reset state
        #2;
        chk_rsp("reset", 1'b0, 2'd0, 4'h0);
        chk("reset.req_ready", 32'(dif.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;

        // 1: single request, idx 3 -> entry 3 = 4
        dif.req_valid = 4'b0001;
        dif.req_index = 8'b00_00_00_11;
        #1;
        chk("t1.grant", 32'(dif.req_ready), 32'b0001);
        tick();
        dif.req_valid = 4'b0000;
        chk_rsp("t1.rsp", 1'b1, 2'd0, 4'h4);

        // Reset so round-robin starts at 0
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;

        // 2: all valid, idx 0 -> entry 0 = 1, grants 0,1,2,3,0
        dif.req_valid = 4'b1111;
        dif.req_index = 8'h00;
        dif.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t2.grant%0d", k), 32'(dif.req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk_rsp($sformatf("t2.rsp%0d", k), 1'b1, 2'(k % 4), 4'h1);
        end
        // ptr now 1, response FULL with id 0 data 1

        // 3: backpressure for 3 cycles, req1 idx1 -> entry 1 = 2
        dif.req_valid = 4'b0010;
        dif.req_index = 8'b00_00_01_00;
        dif.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t3.stall_grant%0d", k), 32'(dif.req_ready), 32'h0);
            chk_rsp($sformatf("t3.stall%0d", k), 1'b1, 2'd0, 4'h1);
            tick();
        end
        dif.rsp_ready = 1'b1;
        #1;
        chk("t3.release_grant", 32'(dif.req_ready), 32'b0010);
        tick();
        dif.req_valid = 4'b0000;
        chk_rsp("t3.rsp", 1'b1, 2'd1, 4'h2);
        // ptr now 2

        // 4: write entry 2 = A while req2 looks up idx 2 -> old value 3, then A
        dif.req_valid = 4'b0100;
        dif.req_index = 8'b00_10_00_00;
        dif.cfg_we    = 1'b1;
        dif.cfg_addr  = 2'd2;
        dif.cfg_data  = 4'hA;
        #1;
        chk("t4.grant_a", 32'(dif.req_ready), 32'b0100);
        tick();
        dif.cfg_we = 1'b0;
        chk_rsp("t4.old", 1'b1, 2'd2, 4'h3);
        #1;
        chk("t4.grant_b", 32'(dif.req_ready), 32'b0100);
        tick();
        dif.req_valid = 4'b0000;
        chk_rsp("t4.new", 1'b1, 2'd2, 4'hA);
        // ptr now 3

        // 5: only req3 (idx1 -> 2) and req0 (idx0 -> 1) valid: 3, 0, 3
        dif.req_valid = 4'b1001;
        dif.req_index = 8'b01_00_00_00;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t5.grant%0d", k), 32'(dif.req_ready),
                (k % 2 == 0) ? 32'b1000 : 32'b0001);
            tick();
            chk($sformatf("t5.id%0d", k), 32'(dif.rsp_id), (k % 2 == 0) ? 32'd3 : 32'd0);
            chk($sformatf("t5.data%0d", k), 32'(dif.rsp_data), (k % 2 == 0) ? 32'h2 : 32'h1);
        end
        // ptr now 0; drain with no grant -> EMPTY
        dif.req_valid = 4'b0000;
        #1;
        chk("t5.idle_grant", 32'(dif.req_ready), 32'h0);
        tick();
        chk("t5.drain", 32'(dif.rsp_valid), 32'h0);

        // Move ptr off 0 (grant req1 -> ptr 2) and leave the response FULL
        dif.req_valid = 4'b0010;
        dif.req_index = 8'h00;
        dif.rsp_ready = 1'b0;
        tick();
        dif.req_valid = 4'b0000;
        chk_rsp("t6.pre", 1'b1, 2'd1, 4'h1);

        // 6: async reset discards response and restores table and ptr
        #2;
        rst = 1'b1;
        #1;
        chk_rsp("t6.reset", 1'b0, 2'd0, 4'h0);
        tick();
        rst = 1'b0;
        dif.req_valid = 4'b1111;
        dif.req_index = 8'b10_10_10_10;
        dif.rsp_ready = 1'b1;
        #1;
        chk("t6.grant", 32'(dif.req_ready), 32'b0001);
        tick();
        dif.req_valid = 4'b0000;
        chk_rsp("t6.rsp", 1'b1, 2'd0, 4'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
